// File: rtl/cve2_rf_arb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
`default_nettype none

package cve2_rf_arb_pkg;

  localparam int unsigned MaxReq      = 4;
  localparam int unsigned WbDataWidth = 32;

  typedef struct packed {
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
  } wb_req_t;

  // Under RV32E only x0..x15 exist; bit 4 set marks a nonexistent register.
  function automatic logic addr_legal(input logic [4:0] addr, input logic rv32e);
    return !(rv32e && addr[4]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cve2_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, rotating priority pointer held internally.
`default_nettype none

module cve2_rr_arbiter
  import cve2_rf_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] ptr_d;
  logic            found;

  // Scan from the pointer upwards, wrapping; the first valid requester wins.
  always_comb begin : p_select
    int c;
    c         = 0;
    found     = 1'b0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N) c = c - N;
      if (!found && req_i[c]) begin
        found     = 1'b1;
        gnt_idx_o = IdxW'(c);
      end
    end
    if (en_i && found) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : IdxW'(int'(gnt_idx_o) + 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/cve2_rf_wb_arbiter.sv
// Write-back arbiter, output stage and pending-write scoreboard for the single-port RF.
// Scoreboard is built only when CVE2_RF_WB_SCOREBOARD_EN is defined.
`default_nettype none

module cve2_rf_wb_arbiter
  import cve2_rf_arb_pkg::*;
#(
  parameter int NumReq    = 3,
  parameter int DataWidth = 32,
  parameter bit RV32E     = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*5-1:0]           req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic                          alloc_i,
  input  logic [4:0]                    alloc_addr_i,
  input  logic [4:0]                    raddr_a_i,
  input  logic [4:0]                    raddr_b_i,
  input  logic [4:0]                    raddr_c_i,
  output logic                          hazard_a_o,
  output logic                          hazard_b_o,
  output logic                          hazard_c_o,
  output logic                          rf_we_o,
  output logic [4:0]                    rf_waddr_o,
  output logic [DataWidth-1:0]          rf_wdata_o,
  output logic                          illegal_o
);

  localparam int IdxW = $clog2(NumReq);

  logic [NumReq-1:0]    gnt;
  logic [IdxW-1:0]      gnt_idx;
  logic                 accept;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_legal;
  logic                 we_d;
  logic                 illegal_d;

  // Holding the arbiter disabled in reset keeps requests from being granted.
  cve2_rr_arbiter #(
    .N(NumReq)
  ) u_rr_arbiter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (rst_ni),
    .req_i    (req_valid_i),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  assign req_ready_o = gnt;
  assign accept      = |gnt;
  assign sel_addr    = req_addr_i[gnt_idx*5 +: 5];
  assign sel_data    = req_data_i[gnt_idx*DataWidth +: DataWidth];
  assign sel_legal   = addr_legal(sel_addr, RV32E);
  assign we_d        = accept && (sel_addr != 5'd0) && sel_legal;
  assign illegal_d   = accept && !sel_legal;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      illegal_o  <= 1'b0;
    end else begin
      rf_we_o   <= we_d;
      illegal_o <= illegal_d;
      if (we_d) begin
        rf_waddr_o <= sel_addr;
        rf_wdata_o <= sel_data;
      end
    end
  end

  logic stage_a, stage_b, stage_c;
  assign stage_a = rf_we_o && (rf_waddr_o == raddr_a_i) && (raddr_a_i != 5'd0);
  assign stage_b = rf_we_o && (rf_waddr_o == raddr_b_i) && (raddr_b_i != 5'd0);
  assign stage_c = rf_we_o && (rf_waddr_o == raddr_c_i) && (raddr_c_i != 5'd0);

`ifdef CVE2_RF_WB_SCOREBOARD_EN
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        alloc_ok;

  assign alloc_ok = alloc_i && (alloc_addr_i != 5'd0) && addr_legal(alloc_addr_i, RV32E);

  // Set is applied after clear so a same-cycle reallocation survives the older write.
  always_comb begin
    pending_d = pending_q;
    if (we_d)     pending_d[sel_addr]     = 1'b0;
    if (alloc_ok) pending_d[alloc_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign hazard_a_o = pending_q[raddr_a_i] || stage_a;
  assign hazard_b_o = pending_q[raddr_b_i] || stage_b;
  assign hazard_c_o = pending_q[raddr_c_i] || stage_c;
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc_i, alloc_addr_i};

  assign hazard_a_o = stage_a;
  assign hazard_b_o = stage_b;
  assign hazard_c_o = stage_c;
`endif

endmodule

`default_nettype wire
